// File: rtl/wb_arbiter_rr_if.sv
// Wishbone B3 shared-bus bundle for wb_arbiter_rr: packed per-master request
// lanes, the single slave-side port and the one-hot grant.
interface wb_arbiter_rr_if #(
  parameter int MASTERS = 3,
  parameter int AW      = 32,
  parameter int DW      = 32
);
  logic [MASTERS-1:0]        m_cyc;
  logic [MASTERS-1:0]        m_stb;
  logic [MASTERS-1:0]        m_we;
  logic [MASTERS*AW-1:0]     m_adr;
  logic [MASTERS*DW-1:0]     m_dat_m2s;
  logic [MASTERS*DW/8-1:0]   m_sel;
  logic [MASTERS*3-1:0]      m_cti;
  logic [MASTERS*2-1:0]      m_bte;
  logic [DW-1:0]             m_dat_s2m;
  logic [MASTERS-1:0]        m_ack;
  logic [MASTERS-1:0]        m_err;

  logic                      s_cyc;
  logic                      s_stb;
  logic                      s_we;
  logic [AW-1:0]             s_adr;
  logic [DW-1:0]             s_dat_m2s;
  logic [DW/8-1:0]           s_sel;
  logic [2:0]                s_cti;
  logic [1:0]                s_bte;
  logic [DW-1:0]             s_dat_s2m;
  logic                      s_ack;
  logic                      s_err;

  logic [MASTERS-1:0]        grant;

  // Arbiter view: consumes master requests and slave responses.
  modport slave (
    input  m_cyc, m_stb, m_we, m_adr, m_dat_m2s, m_sel, m_cti, m_bte,
    input  s_dat_s2m, s_ack, s_err,
    output m_dat_s2m, m_ack, m_err,
    output s_cyc, s_stb, s_we, s_adr, s_dat_m2s, s_sel, s_cti, s_bte,
    output grant
  );

  // Environment view: the requesting masters plus the responding slave.
  modport master (
    output m_cyc, m_stb, m_we, m_adr, m_dat_m2s, m_sel, m_cti, m_bte,
    output s_dat_s2m, s_ack, s_err,
    input  m_dat_s2m, m_ack, m_err,
    input  s_cyc, s_stb, s_we, s_adr, s_dat_m2s, s_sel, s_cti, s_bte,
    input  grant
  );
endinterface

// File: rtl/wb_arbiter_rr.sv
// Round-robin Wishbone B3 arbiter: one owner per cyc tenure, no preemption.
// Optional slave-hang watchdog enabled by defining WB_ARB_WATCHDOG_EN.
module wb_arbiter_rr #(
  parameter int MASTERS = 3,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           rst,
  wb_arbiter_rr_if.slave bus
);

  localparam int LW = $clog2(MASTERS);
  localparam int SW = DW / 8;
  // Out-of-range configurations never grant, so a bad build shows up as a dead bus.
  localparam bit CFG_OK = (MASTERS >= 2) && (MASTERS <= 8) &&
                          (TIMEOUT >= 1) && (TIMEOUT <= 65535) && (DW % 8 == 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1
`ifdef WB_ARB_WATCHDOG_EN
    , ST_ABORT = 2'd2
`endif
  } state_e;

  state_e             state_q;
  logic [MASTERS-1:0] grant_q;
  logic [LW-1:0]      owner_q;
  logic [LW-1:0]      last_q;

`ifdef WB_ARB_WATCHDOG_EN
  localparam logic [15:0] WDOG_LIMIT = 16'(TIMEOUT);
  logic [15:0]        wdog_q;
  logic               abort_err_q;
`endif

  logic [MASTERS-1:0] grant_d;
  logic [LW-1:0]      owner_d;
  logic               req_vld;

  function automatic logic [LW-1:0] rr_idx(input logic [LW-1:0] base, input int k);
    return LW'((int'(base) + k) % MASTERS);
  endfunction

  // Scan from farthest to nearest so the first requester after last_q overwrites the rest.
  always_comb begin
    req_vld = 1'b0;
    owner_d = '0;
    grant_d = '0;
    for (int k = MASTERS; k >= 1; k--) begin
      if (bus.m_cyc[rr_idx(last_q, k)]) begin
        req_vld = CFG_OK;
        owner_d = rr_idx(last_q, k);
      end
    end
    grant_d[owner_d] = req_vld;
  end

  logic          own_cyc, own_stb, own_we;
  logic [AW-1:0] own_adr;
  logic [DW-1:0] own_dat;
  logic [SW-1:0] own_sel;
  logic [2:0]    own_cti;
  logic [1:0]    own_bte;

  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    own_adr = '0;
    own_dat = '0;
    own_sel = '0;
    own_cti = '0;
    own_bte = '0;
    for (int i = 0; i < MASTERS; i++) begin
      if (grant_q[i]) begin
        own_cyc = bus.m_cyc[i];
        own_stb = bus.m_stb[i];
        own_we  = bus.m_we[i];
        own_adr = bus.m_adr[i*AW +: AW];
        own_dat = bus.m_dat_m2s[i*DW +: DW];
        own_sel = bus.m_sel[i*SW +: SW];
        own_cti = bus.m_cti[i*3 +: 3];
        own_bte = bus.m_bte[i*2 +: 2];
      end
    end
  end

  logic own_act;
  assign own_act = (state_q == ST_OWN);

  assign bus.s_cyc     = own_act & own_cyc;
  assign bus.s_stb     = own_act & own_cyc & own_stb;
  assign bus.s_we      = own_act & own_we;
  assign bus.s_adr     = own_act ? own_adr : '0;
  assign bus.s_dat_m2s = own_act ? own_dat : '0;
  assign bus.s_sel     = own_act ? own_sel : '0;
  assign bus.s_cti     = own_act ? own_cti : '0;
  assign bus.s_bte     = own_act ? own_bte : '0;

  assign bus.m_dat_s2m = bus.s_dat_s2m;
  assign bus.m_ack     = own_act ? (grant_q & {MASTERS{bus.s_ack}}) : '0;
  assign bus.grant     = grant_q;

`ifdef WB_ARB_WATCHDOG_EN
  assign bus.m_err = (own_act ? (grant_q & {MASTERS{bus.s_err}}) : '0) |
                     (abort_err_q ? grant_q : '0);

  logic stall;
  assign stall = bus.s_stb & ~bus.s_ack & ~bus.s_err;
`else
  assign bus.m_err = own_act ? (grant_q & {MASTERS{bus.s_err}}) : '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      owner_q     <= '0;
      last_q      <= LW'(MASTERS - 1);
`ifdef WB_ARB_WATCHDOG_EN
      wdog_q      <= '0;
      abort_err_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_vld) begin
            state_q <= ST_OWN;
            grant_q <= grant_d;
            owner_q <= owner_d;
          end
        end
        ST_OWN: begin
          if (!own_cyc) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= owner_q;
`ifdef WB_ARB_WATCHDOG_EN
            wdog_q  <= '0;
          end else if (wdog_q == WDOG_LIMIT) begin
            state_q     <= ST_ABORT;
            abort_err_q <= 1'b1;
            wdog_q      <= '0;
          end else if (stall) begin
            wdog_q <= wdog_q + 16'd1;
          end else begin
            wdog_q <= '0;
`endif
          end
        end
`ifdef WB_ARB_WATCHDOG_EN
        // Slave is cut off; hold the grant until the stuck master gives up cyc.
        ST_ABORT: begin
          abort_err_q <= 1'b0;
          if (!own_cyc) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= owner_q;
          end
        end
`endif
        default: begin
          state_q <= ST_IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Self-checking bench for wb_arbiter_rr: vector table, directed corner
// sequences and random traffic scored against a tenure-level reference model.
module tb_wb_arbiter_rr;

  localparam int M  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  wb_arbiter_rr_if #(.MASTERS(M), .AW(AW), .DW(DW)) bus ();

  wb_arbiter_rr #(.MASTERS(M), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: owner index (-1 when nobody holds the bus), rr pointer,
  // watchdog stall count and abort status.
  int mo_owner = -1;
  int mo_last  = M - 1;
  int mo_cnt   = 0;
  bit mo_abort = 1'b0;
  bit mo_first = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mo_owner = -1;
    mo_last  = M - 1;
    mo_cnt   = 0;
    mo_abort = 1'b0;
    mo_first = 1'b0;
  endtask

  task automatic model_check();
    logic [M-1:0]    eg, eack, eerr;
    logic            ecyc, estb;
    logic [AW-1:0]   eadr;
    logic [DW-1:0]   edat;
    logic [9:0]      ectl;
    int o;
    eg = '0; eack = '0; eerr = '0; ecyc = 1'b0; estb = 1'b0;
    eadr = '0; edat = '0; ectl = '0;
    o = mo_owner;
    if (o >= 0) begin
      eg[o] = 1'b1;
      if (!mo_abort) begin
        ecyc    = bus.m_cyc[o];
        estb    = bus.m_stb[o] & bus.m_cyc[o];
        eadr    = bus.m_adr[o*AW +: AW];
        edat    = bus.m_dat_m2s[o*DW +: DW];
        ectl    = {bus.m_we[o], bus.m_sel[o*4 +: 4], bus.m_cti[o*3 +: 3], bus.m_bte[o*2 +: 2]};
        eack[o] = bus.s_ack;
        eerr[o] = bus.s_err;
      end else if (mo_first) begin
        eerr[o] = 1'b1;
      end
    end
    chk("model_grant", bus.grant, eg);
    chk("model_m_ack", bus.m_ack, eack);
    chk("model_m_err", bus.m_err, eerr);
    chk("model_s_cyc_stb", {bus.s_cyc, bus.s_stb}, {ecyc, estb});
    chk("model_s_adr", bus.s_adr, eadr);
    chk("model_s_dat", bus.s_dat_m2s, edat);
    chk("model_s_ctl", {bus.s_we, bus.s_sel, bus.s_cti, bus.s_bte}, ectl);
    chk("model_m_dat", bus.m_dat_s2m, bus.s_dat_s2m);
  endtask

  task automatic model_step();
    int o;
    if (!rst) begin
      model_reset();
      return;
    end
    o = mo_owner;
    if (o < 0) begin
      for (int k = 1; k <= M; k++) begin
        if (bus.m_cyc[(mo_last + k) % M]) begin
          mo_owner = (mo_last + k) % M;
          break;
        end
      end
    end else if (mo_abort) begin
      mo_first = 1'b0;
      if (!bus.m_cyc[o]) begin
        mo_owner = -1;
        mo_last  = o;
        mo_abort = 1'b0;
      end
    end else if (!bus.m_cyc[o]) begin
      mo_owner = -1;
      mo_last  = o;
      mo_cnt   = 0;
    end
`ifdef WB_ARB_WATCHDOG_EN
    else if (mo_cnt == TO) begin
      mo_abort = 1'b1;
      mo_first = 1'b1;
      mo_cnt   = 0;
    end else begin
      mo_cnt = (bus.m_stb[o] && !bus.s_ack && !bus.s_err) ? mo_cnt + 1 : 0;
    end
`endif
  endtask

  task automatic to_sample();
    @(negedge clk);
  endtask

  task automatic advance();
    model_check();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.m_cyc = '0; bus.m_stb = '0; bus.m_we = '0; bus.m_adr = '0;
    bus.m_dat_m2s = '0; bus.m_sel = '0; bus.m_cti = '0; bus.m_bte = '0;
    bus.s_dat_s2m = '0; bus.s_ack = 1'b0; bus.s_err = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    model_reset();
    repeat (2) begin
      to_sample();
      advance();
    end
    rst = 1'b1;
  endtask

  typedef struct {
    logic [M-1:0] cyc;
    logic         ack;
    logic [M-1:0] g;
    logic [M-1:0] mack;
    logic         scyc;
  } vec_t;

  vec_t tbl [11];

  initial begin
    int acks, other_acks, errs, exp_g;
    bit bad_grant, err_seen;

    tbl[0]  = '{3'b111, 1'b0, 3'b000, 3'b000, 1'b0};
    tbl[1]  = '{3'b111, 1'b1, 3'b001, 3'b001, 1'b1};
    tbl[2]  = '{3'b110, 1'b0, 3'b001, 3'b000, 1'b0};
    tbl[3]  = '{3'b111, 1'b0, 3'b000, 3'b000, 1'b0};
    tbl[4]  = '{3'b111, 1'b1, 3'b010, 3'b010, 1'b1};
    tbl[5]  = '{3'b101, 1'b0, 3'b010, 3'b000, 1'b0};
    tbl[6]  = '{3'b111, 1'b0, 3'b000, 3'b000, 1'b0};
    tbl[7]  = '{3'b111, 1'b1, 3'b100, 3'b100, 1'b1};
    tbl[8]  = '{3'b011, 1'b0, 3'b100, 3'b000, 1'b0};
    tbl[9]  = '{3'b111, 1'b0, 3'b000, 3'b000, 1'b0};
    tbl[10] = '{3'b111, 1'b0, 3'b001, 3'b000, 1'b1};

    // Reset state.
    clear_inputs();
    rst = 1'b0;
    to_sample();
    chk("reset_grant", bus.grant, 3'b000);
    chk("reset_s_cyc_stb", {bus.s_cyc, bus.s_stb}, 2'b00);
    chk("reset_m_ack_err", {bus.m_ack, bus.m_err}, 6'b0);
    advance();
    do_reset();

    // Single master with a two-cycle slave response.
    bus.m_cyc = 3'b010;
    bus.m_stb = 3'b010;
    bus.m_adr[1*AW +: AW] = 32'h0000_4010;
    acks = 0;
    other_acks = 0;
    for (int c = 0; c < 6; c++) begin
      bus.s_ack = (c == 3);
      to_sample();
      chk("single_grant", bus.grant, (c == 0) ? 3'b000 : 3'b010);
      if (c == 1) begin
        chk("single_s_adr", bus.s_adr, 32'h0000_4010);
        chk("single_s_stb", bus.s_stb, 1'b1);
      end
      if (c == 3) chk("single_ack_cycle", bus.m_ack, 3'b010);
      acks += int'(bus.m_ack[1]);
      other_acks += int'(bus.m_ack[0]) + int'(bus.m_ack[2]);
      advance();
    end
    chk("single_ack_count", acks, 1);
    chk("single_other_acks", other_acks, 0);

    // Three-way contention, table driven.
    do_reset();
    for (int r = 0; r < 11; r++) begin
      bus.m_cyc = tbl[r].cyc;
      bus.m_stb = tbl[r].cyc;
      bus.s_ack = tbl[r].ack;
      to_sample();
      chk($sformatf("tbl%0d_grant", r), bus.grant, tbl[r].g);
      chk($sformatf("tbl%0d_m_ack", r), bus.m_ack, tbl[r].mack);
      chk($sformatf("tbl%0d_s_cyc", r), bus.s_cyc, tbl[r].scyc);
      advance();
    end

    // Burst of 8 beats on master 0 while master 2 waits.
    do_reset();
    bus.m_cyc = 3'b101;
    bus.m_stb = 3'b101;
    bus.m_cti[2:0] = 3'b010;
    acks = 0;
    other_acks = 0;
    for (int c = 0; c < 12; c++) begin
      bus.s_ack = (c >= 1 && c <= 8);
      if (c == 8) bus.m_cti[2:0] = 3'b111;
      if (c == 9) begin
        bus.m_cyc[0] = 1'b0;
        bus.m_stb[0] = 1'b0;
      end
      exp_g = (c == 0) ? 0 : (c <= 9) ? 1 : (c == 10) ? 0 : 4;
      to_sample();
      chk("burst_grant", bus.grant, exp_g);
      if (c >= 1 && c <= 8) chk("burst_s_cti", bus.s_cti, (c == 8) ? 3'b111 : 3'b010);
      if (c <= 9) begin
        acks += int'(bus.m_ack[0]);
        other_acks += int'(bus.m_ack[2]);
      end
      advance();
    end
    chk("burst_beats", acks, 8);
    chk("burst_m2_acks", other_acks, 0);

    // Asynchronous reset in the middle of a tenure.
    do_reset();
    bus.m_cyc = 3'b010;
    bus.m_stb = 3'b010;
    to_sample();
    advance();
    to_sample();
    chk("arst_pre_grant", bus.grant, 3'b010);
    chk("arst_pre_s_stb", bus.s_stb, 1'b1);
    advance();
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("arst_grant", bus.grant, 3'b000);
    chk("arst_s_cyc", bus.s_cyc, 1'b0);
    bus.m_cyc = 3'b111;
    bus.m_stb = 3'b111;
    to_sample();
    advance();
    rst = 1'b1;
    to_sample();
    chk("arst_post_idle", bus.grant, 3'b000);
    advance();
    to_sample();
    chk("arst_post_grant", bus.grant, 3'b001);
    advance();

    // Slave that never answers.
    do_reset();
    bus.m_cyc = 3'b100;
    bus.m_stb = 3'b100;
`ifdef WB_ARB_WATCHDOG_EN
    errs = 0;
    for (int c = 0; c < 13; c++) begin
      if (c == 2) begin
        bus.m_cyc[0] = 1'b1;
        bus.m_stb[0] = 1'b1;
      end
      if (c == 9) begin
        bus.m_cyc[2] = 1'b0;
        bus.m_stb[2] = 1'b0;
      end
      exp_g = (c == 0) ? 0 : (c <= 9) ? 4 : (c == 10) ? 0 : 1;
      to_sample();
      chk("wdog_grant", bus.grant, exp_g);
      if (c <= 10) begin
        chk("wdog_m_err", bus.m_err, (c == 6) ? 3'b100 : 3'b000);
        chk("wdog_s_cyc", bus.s_cyc, (c >= 1 && c <= 5));
        errs += int'(bus.m_err[2]);
      end
      advance();
    end
    chk("wdog_err_pulses", errs, 1);
`else
    bad_grant = 1'b0;
    err_seen = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      to_sample();
      if (c >= 1 && bus.grant !== 3'b100) bad_grant = 1'b1;
      if (bus.m_err !== 3'b000) err_seen = 1'b1;
      advance();
    end
    chk("hang_grant_held", bad_grant, 1'b0);
    chk("hang_no_err", err_seen, 1'b0);
`endif

    // Random traffic against the reference model.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < M; i++) begin
        if ($urandom_range(0, 3) == 0) bus.m_cyc[i] = ~bus.m_cyc[i];
      end
      bus.m_stb     = 3'($urandom);
      bus.m_we      = 3'($urandom);
      bus.m_adr     = {$urandom, $urandom, $urandom};
      bus.m_dat_m2s = {$urandom, $urandom, $urandom};
      bus.m_sel     = 12'($urandom);
      bus.m_cti     = 9'($urandom);
      bus.m_bte     = 6'($urandom);
      bus.s_dat_s2m = $urandom;
      bus.s_ack     = ($urandom_range(0, 2) == 0);
      bus.s_err     = ($urandom_range(0, 7) == 0);
      to_sample();
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_arbiter_rr.md
Name: wb_arbiter_rr

Overview:
Round-robin Wishbone B3 shared-bus arbiter. It sits between the CPU instruction port, the CPU data port and the external LCD DMA master on the master side, and the address expander on the slave side. It grants exactly one master per bus tenure and holds the grant until that master drops cyc. An optional watchdog aborts tenures where the slave never responds.

Parameters:
MASTERS, 3, number of requesting masters (2..8)
AW, 32, address width
DW, 32, data width (multiple of 8)
TIMEOUT, 255, watchdog limit in cycles of stb-without-ack/err (1..65535)

Ports:
clk  in  1  bus clock
rst  in  1  asynchronous reset, active-low
m_cyc  in  MASTERS  per-master cycle request
m_stb  in  MASTERS  per-master strobe
m_we  in  MASTERS  per-master write enable
m_adr  in  MASTERS*AW  packed addresses, master i at [i*AW +: AW]
m_dat_m2s  in  MASTERS*DW  packed write data
m_sel  in  MASTERS*DW/8  packed byte selects
m_cti  in  MASTERS*3  packed cycle type
m_bte  in  MASTERS*2  packed burst type
m_dat_s2m  out  DW  read data, broadcast to all masters
m_ack  out  MASTERS  per-master ack
m_err  out  MASTERS  per-master err
s_cyc, s_stb, s_we  out  1  to slave side
s_adr  out  AW  to slave
s_dat_m2s  out  DW  to slave
s_sel  out  DW/8  to slave
s_cti  out  3  to slave
s_bte  out  2  to slave
s_dat_s2m  in  DW  slave read data
s_ack, s_err  in  1  slave response
grant  out  MASTERS  one-hot current owner, 0 when idle

Behaviour:
- Reset (rst=0, async): state IDLE; grant=0; rr pointer last=MASTERS-1, so master 0 wins first; s_cyc=s_stb=0; m_ack=m_err=0; watchdog counter=0.
- States: IDLE, OWN, ABORT (ABORT exists only with the macro).
- IDLE: if any m_cyc is set, select the first requester scanning last+1, last+2, ... modulo MASTERS. grant is registered, so the owner sees s_cyc one cycle after raising m_cyc (1-cycle arbitration latency). No m_cyc set: stay in IDLE.
- OWN: s_* = owner's m_* combinationally, gated by grant (s_cyc=m_cyc[o], s_stb=m_stb[o]&m_cyc[o]).
- OWN routing: m_ack[o]=s_ack, m_err[o]=s_err; every non-owner's ack/err is held at 0. m_dat_s2m=s_dat_s2m always.
- OWN exit: m_cyc[o]=0 -> IDLE next cycle, last=o, grant=0. This forces at least one idle cycle between tenures.
- No preemption: lower-priority requests wait for the full tenure, including bursts (cti=010) and back-to-back stb pulses under one cyc.
- Simultaneous requests from all masters, back-to-back: grant order 0,1,2,0,... Each requester is guaranteed service within MASTERS-1 tenures.
- A requester dropping m_cyc before it is granted is simply skipped.
- rst asserted mid-tenure: everything returns to reset values immediately. Masters observe loss of ack.
- Outputs in IDLE: s_adr, s_dat_m2s, s_sel, s_cti, s_bte, s_we driven 0.

Optional Feature:
Macro WB_ARB_WATCHDOG_EN.
- Defined: a 16-bit counter increments each OWN cycle with s_stb=1 and s_ack=s_err=0. It clears on any ack/err, on stb low, and on leaving OWN.
- Counter reaching TIMEOUT: enter ABORT next cycle.
  - ABORT first cycle: m_err[o]=1 for exactly 1 cycle; s_cyc=s_stb=0.
  - ABORT remaining cycles: s_cyc=s_stb=0; slave responses are ignored.
  - ABORT exit: m_cyc[o]=0 -> IDLE, last=o.
- Not defined: no counter, no ABORT state. A hung slave holds the bus indefinitely, and m_err only passes through s_err.

Test Plan:
- Single master: m_cyc[1]=m_stb[1]=1, adr=0x00004010, slave acks 2 cycles after s_stb -> grant=3'b010 one cycle later; s_adr=0x00004010; m_ack[1] pulses once; m_ack[0], m_ack[2]=0.
- Contention: all three m_cyc rise in the same cycle, each tenure is 1 ack then cyc drops, requests reasserted immediately -> grant sequence 001,000,010,000,100,000,001.
- Burst hold: master 0 holds cyc for 8 acked beats, cti=010 then 111, while master 2 requests -> master 2 not granted until the cycle after m_cyc[0] falls; no beat lost.
- Async reset mid-tenure: rst=0 while grant=010 and s_stb=1 -> grant=0, s_cyc=0 in the same cycle; after release, master 0 wins a 3-way contest.
- Watchdog (WB_ARB_WATCHDOG_EN, TIMEOUT=4): master 2 granted, slave never acks -> m_err[2]=1 for exactly one cycle, 5 cycles after s_stb rose; s_cyc=0 from then on; master 0 granted after m_cyc[2] falls.
- Watchdog absent: same stimulus for 1000 cycles -> m_err stays 0 and grant stays 100.
